// File: rtl/cache_arbiter_if.sv
// Cache-line memory bus shared by the I-cache, the D-cache and the backing memory port.
//
// Signals:
//   read, write  line read / writeback command (master -> slave)
//   address      byte address of the line      (master -> slave)
//   wdata        writeback line data           (master -> slave)
//   rdata        returned line data            (slave -> master)
//   resp         one-cycle completion strobe   (slave -> master)
//
// Modports: master issues commands; slave answers them.
interface cache_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
);
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic [LINE_WIDTH-1:0] wdata;
  logic [LINE_WIDTH-1:0] rdata;
  logic                  resp;

  modport master (output read, output write, output address, output wdata,
                  input rdata, input resp);
  modport slave  (input read, input write, input address, input wdata,
                  output rdata, output resp);
endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates one physical-memory port between an I-cache and a D-cache.
// An idle request is granted one cycle later. The grant is held until the
// memory returns resp, which sends the arbiter back to idle for at least one
// cycle. While a cache is being served, the command follows that cache's live inputs.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-high reset
//   i_pmem  I-cache bus (slave side; the write and wdata inputs are ignored)
//   d_pmem  D-cache bus (slave side)
//   pmem    shared memory bus (master side)
//
// Configuration:
//   CACHE_ARB_ROUND_ROBIN_EN  when defined, ties alternate using a last_grant bit.
//                             When undefined, the D-cache always wins ties.
module cache_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  cache_arbiter_if.slave   i_pmem,
  cache_arbiter_if.slave   d_pmem,
  cache_arbiter_if.master  pmem
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  state_e state_q, state_d;
  logic   i_req, d_req, tie_pick_d;

  assign i_req = i_pmem.read;
  assign d_req = d_pmem.read | d_pmem.write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // 1 = D was granted last, 0 = I was granted last.
  logic last_grant_q, last_grant_d;

  assign tie_pick_d = ~last_grant_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign tie_pick_d = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      StIdle: begin
        // A resp that arrives while idle (for example after a reset) is ignored.
        if (d_req && (!i_req || tie_pick_d)) begin
          state_d = StServeD;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
          last_grant_d = 1'b1;
`endif
        end else if (i_req) begin
          state_d = StServeI;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
          last_grant_d = 1'b0;
`endif
        end
      end
      StServeI, StServeD: begin
        if (pmem.resp) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pmem.read    = 1'b0;
    pmem.write   = 1'b0;
    pmem.address = {ADDR_WIDTH{1'b0}};
    pmem.wdata   = {LINE_WIDTH{1'b0}};
    unique case (state_q)
      StServeI: begin
        pmem.read    = 1'b1;
        pmem.address = i_pmem.address;
      end
      StServeD: begin
        // A write with read also asserted is a writeback only.
        pmem.read    = d_pmem.read & ~d_pmem.write;
        pmem.write   = d_pmem.write;
        pmem.address = d_pmem.address;
        pmem.wdata   = d_pmem.wdata;
      end
      default: ;
    endcase
  end

  assign i_pmem.rdata = pmem.rdata;
  assign d_pmem.rdata = pmem.rdata;
  assign i_pmem.resp  = pmem.resp & (state_q == StServeI);
  assign d_pmem.resp  = pmem.resp & (state_q == StServeD);

  // The I-cache never writes.
  logic unused_i_write;
  assign unused_i_write = ^{i_pmem.write, i_pmem.wdata};

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: I-cache fill, tie handling, D-cache writeback,
// deassertion during service, reset during service, and rdata pass-through.
module tb_cache_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned LW = 128;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) i_bus ();
  cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) d_bus ();
  cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) m_bus ();

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_pmem (i_bus),
    .d_pmem (d_bus),
    .pmem   (m_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to 2 ns after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Settle time after new inputs are driven and before outputs are sampled.
  task automatic settle();
    #1;
  endtask

  task automatic check_idle_cmd(input string tag);
    check_eq({tag, "_rd"}, m_bus.read, 1'b0);
    check_eq({tag, "_wr"}, m_bus.write, 1'b0);
    check_eq({tag, "_addr"}, m_bus.address, '0);
    check_eq({tag, "_wdata"}, m_bus.wdata, '0);
  endtask

  logic [LW-1:0] pat;
  logic [AW-1:0] exp_addr [3];

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    i_bus.read = 1'b0; i_bus.write = 1'b0; i_bus.address = '0; i_bus.wdata = '0;
    d_bus.read = 1'b0; d_bus.write = 1'b0; d_bus.address = '0; d_bus.wdata = '0;
    m_bus.rdata = '0; m_bus.resp = 1'b0;

    // Reset state: commands stay 0 even while a request is pending.
    tick();
    i_bus.read = 1'b1; i_bus.address = 16'h1230;
    tick();
    check_idle_cmd("reset");
    check_eq("reset_iresp", i_bus.resp, 1'b0);
    check_eq("reset_dresp", d_bus.resp, 1'b0);
    i_bus.read = 1'b0;
    tick();
    reset = 1'b0;

    // I-only fill at 0x1230; memory responds on the 4th command cycle.
    tick();
    i_bus.read = 1'b1; i_bus.address = 16'h1230;
    settle();
    check_eq("ifill_latency_rd", m_bus.read, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq("ifill_rd", m_bus.read, 1'b1);
      check_eq("ifill_wr", m_bus.write, 1'b0);
      check_eq("ifill_addr", m_bus.address, 16'h1230);
      if (c == 3) m_bus.resp = 1'b1;
      settle();
      check_eq("ifill_iresp", i_bus.resp, c == 3);
      check_eq("ifill_dresp", d_bus.resp, 1'b0);
    end
    tick();
    m_bus.resp = 1'b0; i_bus.read = 1'b0;
    settle();
    check_idle_cmd("ifill_done");
    check_eq("ifill_iresp_off", i_bus.resp, 1'b0);

    // Tie: D (0x2000) wins, then I (0x0100) after one idle cycle.
    tick();
    i_bus.read = 1'b1; i_bus.address = 16'h0100;
    d_bus.read = 1'b1; d_bus.address = 16'h2000;
    tick();
    check_eq("tie_d_addr", m_bus.address, 16'h2000);
    check_eq("tie_d_rd", m_bus.read, 1'b1);
    m_bus.resp = 1'b1;
    settle();
    check_eq("tie_d_dresp", d_bus.resp, 1'b1);
    check_eq("tie_d_iresp", i_bus.resp, 1'b0);
    tick();
    m_bus.resp = 1'b0; d_bus.read = 1'b0;
    settle();
    check_eq("tie_gap_rd", m_bus.read, 1'b0);
    tick();
    check_eq("tie_i_addr", m_bus.address, 16'h0100);
    check_eq("tie_i_rd", m_bus.read, 1'b1);
    m_bus.resp = 1'b1;
    settle();
    check_eq("tie_i_iresp", i_bus.resp, 1'b1);
    check_eq("tie_i_dresp", d_bus.resp, 1'b0);
    tick();
    m_bus.resp = 1'b0; i_bus.read = 1'b0;

    // D writeback with read also asserted: treated as write only.
    tick();
    d_bus.read = 1'b1; d_bus.write = 1'b1; d_bus.address = 16'h4440;
    d_bus.wdata = {16{8'hA5}};
    tick();
    check_eq("wb_wr", m_bus.write, 1'b1);
    check_eq("wb_rd", m_bus.read, 1'b0);
    check_eq("wb_addr", m_bus.address, 16'h4440);
    check_eq("wb_wdata", m_bus.wdata, {16{8'hA5}});
    m_bus.resp = 1'b1;
    settle();
    check_eq("wb_dresp", d_bus.resp, 1'b1);
    tick();
    m_bus.resp = 1'b0; d_bus.read = 1'b0; d_bus.write = 1'b0; d_bus.wdata = '0;
    settle();
    check_idle_cmd("wb_done");

    // D deasserts during service: the state holds and the command follows the live inputs.
    tick();
    d_bus.read = 1'b1; d_bus.address = 16'h3000;
    tick();
    check_eq("drop_rd", m_bus.read, 1'b1);
    d_bus.read = 1'b0;
    settle();
    check_eq("drop_live_rd", m_bus.read, 1'b0);
    check_eq("drop_hold_addr", m_bus.address, 16'h3000);
    tick();
    check_eq("drop_still_addr", m_bus.address, 16'h3000);
    m_bus.resp = 1'b1;
    settle();
    check_eq("drop_dresp", d_bus.resp, 1'b1);
    tick();
    m_bus.resp = 1'b0;

    // Reset during SERVE_I; the late resp must be ignored.
    tick();
    i_bus.read = 1'b1; i_bus.address = 16'h1230;
    tick();
    check_eq("rst_mid_rd", m_bus.read, 1'b1);
    reset = 1'b1;
    settle();
    check_idle_cmd("rst_mid");
    i_bus.read = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    m_bus.resp = 1'b1;
    settle();
    check_eq("late_iresp", i_bus.resp, 1'b0);
    check_eq("late_dresp", d_bus.resp, 1'b0);
    tick();
    m_bus.resp = 1'b0;
    settle();
    check_idle_cmd("late_idle");

    // rdata is passed through to both caches, even while idle.
    pat = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
    m_bus.rdata = pat;
    settle();
    check_eq("rdata_i", i_bus.rdata, pat);
    check_eq("rdata_d", d_bus.rdata, pat);
    m_bus.rdata = ~pat;
    settle();
    check_eq("rdata_i_inv", i_bus.rdata, ~pat);
    check_eq("rdata_d_inv", d_bus.rdata, ~pat);

    // Three consecutive ties.
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    exp_addr[0] = 16'hD000; exp_addr[1] = 16'h0A00; exp_addr[2] = 16'hD000;
`else
    exp_addr[0] = 16'hD000; exp_addr[1] = 16'hD000; exp_addr[2] = 16'hD000;
`endif
    tick();
    i_bus.read = 1'b1; i_bus.address = 16'h0A00;
    d_bus.read = 1'b1; d_bus.address = 16'hD000;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("tie3_grant%0d", k), m_bus.address, exp_addr[k]);
      m_bus.resp = 1'b1;
      settle();
      check_eq($sformatf("tie3_dresp%0d", k), d_bus.resp, exp_addr[k] == 16'hD000);
      check_eq($sformatf("tie3_iresp%0d", k), i_bus.resp, exp_addr[k] == 16'h0A00);
      tick();
      m_bus.resp = 1'b0;
    end
    i_bus.read = 1'b0; d_bus.read = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
